// File: rtl/z80_bus_responder_pkg.sv
// Shared definitions for the Z80 bus responder: FSM states, I/O register
// offsets relative to IO_BASE, STATUS bit positions.
package z80_bus_responder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MRD,
        ST_MWR,
        ST_IORD,
        ST_IOWR,
        ST_INTA,
        ST_DONE
    } state_t;

    localparam logic [1:0] REG_VECTOR  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_SCRATCH = 2'd2;
    localparam logic [7:0] REG_COUNT   = 8'd3;

    localparam int STATUS_IE     = 0;
    localparam int STATUS_PEND   = 1;
    localparam int STATUS_BUSERR = 7;

    // STATUS read value; unused bits read as zero.
    function automatic logic [7:0] status_byte(input logic bus_err, input logic pend,
                                               input logic ie);
        logic [7:0] s;
        s                = 8'h00;
        s[STATUS_BUSERR] = bus_err;
        s[STATUS_PEND]   = pend;
        s[STATUS_IE]     = ie;
        return s;
    endfunction

endpackage

// File: rtl/z80_bus_responder_irq_ctrl.sv
// Interrupt requester: synchronises irq_i, turns its rising edge into a
// sticky PEND flag, and drives a registered /INT from PEND & IE.
module z80_irq_ctrl (
    input  logic wb_clk_i,
    input  logic rst_n,
    input  logic irq_i,
    input  logic ie_wr_i,
    input  logic ie_wdata_i,
    input  logic pend_clr_i,
    output logic ie_o,
    output logic pend_o,
    output logic int_n_o
);

    logic sync1_q, sync2_q, prev_q;
    logic pend_q, pend_d;
    logic ie_q, ie_d;
    logic int_n_q;
    logic rise;

    assign rise = sync2_q & ~prev_q;

    // A fresh edge wins over a clear arriving in the same cycle.
    always_comb begin
        pend_d = rise | (pend_q & ~pend_clr_i);
        ie_d   = ie_wr_i ? ie_wdata_i : ie_q;
    end

    // Two-flop synchroniser, edge history, PEND/IE and the /INT output.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            pend_q  <= 1'b0;
            ie_q    <= 1'b0;
            int_n_q <= 1'b1;
        end else begin
            sync1_q <= irq_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            pend_q  <= pend_d;
            ie_q    <= ie_d;
            int_n_q <= ~(pend_q & ie_q);
        end
    end

    assign ie_o    = ie_q;
    assign pend_o  = pend_q;
    assign int_n_o = int_n_q;

endmodule

// File: rtl/z80_bus_responder.sv
// Target side of the Z80 bus: memory window on a ready/valid port with
// /WAIT stretching, three I/O registers, and the IM2 vector for INTA.
//
// state | meaning
// IDLE  | no cycle in progress, watching sampled strobes
// MRD   | memory read request outstanding, /WAIT held low
// MWR   | memory write request outstanding, /WAIT held low
// IORD  | I/O register value placed on the data bus
// IOWR  | I/O register written this cycle
// INTA  | interrupt vector placed on the data bus
// DONE  | response given, waiting for the CPU to end its cycle
module z80_bus_responder
    import z80_bus_responder_pkg::*;
#(
    parameter logic [15:0] MEM_BASE = 16'h0000,
    parameter int          MEM_AW   = 14,
    parameter logic [7:0]  IO_BASE  = 8'h10,
    parameter int          TIMEOUT  = 255
) (
    input  logic              wb_clk_i,
    input  logic              rst_n,
    input  logic [15:0]       a,
    input  logic [7:0]        d_in,
    output logic [7:0]        d_out,
    output logic              d_oe,
    input  logic              m1_n,
    input  logic              mreq_n,
    input  logic              iorq_n,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic              rfsh_n,
    output logic              wait_n,
    output logic              int_n,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_valid,
    output logic              mem_we,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ready,
    input  logic              irq_i,
    output logic              bus_err
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    // Registered strobe samples, active high.
    logic mreq_q, iorq_q, rd_q, wr_q, m1_q, rfsh_q;
    logic [15:0] a_q;
    logic [7:0]  din_q;

    state_t state_q, state_d;
    logic [7:0]        d_out_q, d_out_d;
    logic              d_oe_q, d_oe_d;
    logic              wait_n_q, wait_n_d;
    logic              mem_valid_q, mem_valid_d;
    logic              mem_we_q, mem_we_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              bus_err_q, bus_err_d;
    logic [7:0]        vector_q, vector_d;
    logic [7:0]        scratch_q, scratch_d;
    logic              inta_q, inta_d;

    logic       win_hit, io_hit, mem_cyc;
    logic [7:0] io_off, io_rdata;
    logic       ie, pend, ie_wr, pend_clr;

    assign win_hit = (a_q[15:MEM_AW] == MEM_BASE[15:MEM_AW]);
    assign io_off  = a_q[7:0] - IO_BASE;
    assign io_hit  = (io_off < REG_COUNT);
    assign mem_cyc = mreq_q & ~rfsh_q;

    // Sample the CPU pins once per clock; all decisions use these.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            mreq_q <= 1'b0;
            iorq_q <= 1'b0;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            m1_q   <= 1'b0;
            rfsh_q <= 1'b0;
            a_q    <= 16'h0000;
            din_q  <= 8'h00;
        end else begin
            mreq_q <= ~mreq_n;
            iorq_q <= ~iorq_n;
            rd_q   <= ~rd_n;
            wr_q   <= ~wr_n;
            m1_q   <= ~m1_n;
            rfsh_q <= ~rfsh_n;
            a_q    <= a;
            din_q  <= d_in;
        end
    end

    // I/O register read mux.
    always_comb begin
        io_rdata = 8'h00;
        case (io_off[1:0])
            REG_VECTOR:  io_rdata = vector_q;
            REG_STATUS:  io_rdata = status_byte(bus_err_q, pend, ie);
            REG_SCRATCH: io_rdata = scratch_q;
            default:     io_rdata = 8'h00;
        endcase
    end

    // Next-state, bus outputs and register writes.
    always_comb begin
        state_d     = state_q;
        d_out_d     = d_out_q;
        d_oe_d      = d_oe_q;
        wait_n_d    = wait_n_q;
        mem_valid_d = mem_valid_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cnt_d       = cnt_q;
        bus_err_d   = bus_err_q;
        vector_d    = vector_q;
        scratch_d   = scratch_q;
        inta_d      = inta_q;
        ie_wr       = 1'b0;
        pend_clr    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (m1_q && iorq_q) begin
                    state_d = ST_INTA;
                    d_out_d = vector_q;
                    d_oe_d  = 1'b1;
                    inta_d  = 1'b1;
                end else if (iorq_q && rd_q && io_hit) begin
                    state_d = ST_IORD;
                    d_out_d = io_rdata;
                    d_oe_d  = 1'b1;
                end else if (iorq_q && wr_q && io_hit) begin
                    state_d = ST_IOWR;
                    case (io_off[1:0])
                        REG_VECTOR:  vector_d = din_q;
                        REG_STATUS: begin
                            ie_wr    = 1'b1;
                            pend_clr = din_q[STATUS_PEND];
                            if (din_q[STATUS_BUSERR]) bus_err_d = 1'b0;
                        end
                        REG_SCRATCH: scratch_d = din_q;
                        default: ;
                    endcase
                end else if (mem_cyc && rd_q && win_hit) begin
                    state_d     = ST_MRD;
                    mem_valid_d = 1'b1;
                    mem_we_d    = 1'b0;
                    wait_n_d    = 1'b0;
                    mem_addr_d  = a_q[MEM_AW-1:0];
                    cnt_d       = 8'h00;
                end else if (mem_cyc && wr_q && win_hit) begin
                    state_d     = ST_MWR;
                    mem_valid_d = 1'b1;
                    mem_we_d    = 1'b1;
                    wait_n_d    = 1'b0;
                    mem_addr_d  = a_q[MEM_AW-1:0];
                    mem_wdata_d = din_q;
                    cnt_d       = 8'h00;
                end
            end
            ST_MRD, ST_MWR: begin
                if (mem_ready) begin
                    state_d     = ST_DONE;
                    mem_valid_d = 1'b0;
                    mem_we_d    = 1'b0;
                    wait_n_d    = 1'b1;
                    if (state_q == ST_MRD) begin
                        d_out_d = mem_rdata;
                        d_oe_d  = 1'b1;
                    end
                end else if (cnt_q == TO_LAST) begin
                    // Give up on the backing memory so the CPU is not hung.
                    state_d     = ST_DONE;
                    mem_valid_d = 1'b0;
                    mem_we_d    = 1'b0;
                    wait_n_d    = 1'b1;
                    bus_err_d   = 1'b1;
                    if (state_q == ST_MRD) begin
                        d_out_d = 8'hFF;
                        d_oe_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_IORD, ST_IOWR, ST_INTA: state_d = ST_DONE;
            ST_DONE: begin
                // Refresh MREQ is not part of the cycle being served.
                if (!rd_q && !wr_q && !iorq_q && !mem_cyc) begin
                    state_d  = ST_IDLE;
                    d_oe_d   = 1'b0;
                    inta_d   = 1'b0;
                    pend_clr = inta_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and register state.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            d_out_q     <= 8'h00;
            d_oe_q      <= 1'b0;
            wait_n_q    <= 1'b1;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'h00;
            cnt_q       <= 8'h00;
            bus_err_q   <= 1'b0;
            vector_q    <= 8'hFF;
            scratch_q   <= 8'h00;
            inta_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            d_out_q     <= d_out_d;
            d_oe_q      <= d_oe_d;
            wait_n_q    <= wait_n_d;
            mem_valid_q <= mem_valid_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cnt_q       <= cnt_d;
            bus_err_q   <= bus_err_d;
            vector_q    <= vector_d;
            scratch_q   <= scratch_d;
            inta_q      <= inta_d;
        end
    end

    z80_irq_ctrl u_irq (
        .wb_clk_i   (wb_clk_i),
        .rst_n      (rst_n),
        .irq_i      (irq_i),
        .ie_wr_i    (ie_wr),
        .ie_wdata_i (din_q[STATUS_IE]),
        .pend_clr_i (pend_clr),
        .ie_o       (ie),
        .pend_o     (pend),
        .int_n_o    (int_n)
    );

    assign d_out     = d_out_q;
    assign d_oe      = d_oe_q;
    assign wait_n    = wait_n_q;
    assign mem_valid = mem_valid_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_z80_bus_responder.sv
// Bench for z80_bus_responder: drives CPU bus cycles, models the backing
// SRAM with random latency, and scoreboards data-bus and memory-port traffic.
module tb_z80_bus_responder;

    localparam int K_MRD  = 0;
    localparam int K_MWR  = 1;
    localparam int K_IORD = 2;
    localparam int K_IOWR = 3;
    localparam int K_INTA = 4;
    localparam int K_RFSH = 5;
    localparam logic [7:0] IOB = 8'h10;

    logic        wb_clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] a = 16'h0000;
    logic [7:0]  d_in = 8'h00;
    logic [7:0]  d_out;
    logic        d_oe;
    logic        m1_n = 1'b1, mreq_n = 1'b1, iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, rfsh_n = 1'b1;
    logic        wait_n, int_n;
    logic [13:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_valid, mem_we;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_ready = 1'b0;
    logic        irq_i = 1'b0;
    logic        bus_err;

    z80_bus_responder dut (
        .wb_clk_i  (wb_clk_i),
        .rst_n     (rst_n),
        .a         (a),
        .d_in      (d_in),
        .d_out     (d_out),
        .d_oe      (d_oe),
        .m1_n      (m1_n),
        .mreq_n    (mreq_n),
        .iorq_n    (iorq_n),
        .rd_n      (rd_n),
        .wr_n      (wr_n),
        .rfsh_n    (rfsh_n),
        .wait_n    (wait_n),
        .int_n     (int_n),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_valid (mem_valid),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .irq_i     (irq_i),
        .bus_err   (bus_err)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        logic [13:0] addr;
        logic        we;
        logic [7:0]  wdata;
    } req_t;

    req_t       req_q[$];
    logic [7:0] rd_q[$];
    int         checks = 0;
    int         failures = 0;

    logic [7:0] sram[16384];
    logic [7:0] ref_mem[16384];
    logic [7:0] m_vector = 8'hFF, m_scratch = 8'h00;
    logic       m_ie = 1'b0, m_pend = 1'b0, m_buserr = 1'b0;
    bit         stall = 1'b0;
    int         fix_lat = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Backing SRAM: asserts mem_ready after a random (or fixed) latency.
    initial begin
        int  lat;
        bit  armed;
        lat   = 0;
        armed = 1'b0;
        forever begin
            @(posedge wb_clk_i);
            #1;
            if (!rst_n) begin
                mem_ready = 1'b0;
                armed     = 1'b0;
            end else if (mem_ready) begin
                mem_ready = 1'b0;
            end else if (mem_valid && !stall) begin
                if (!armed) begin
                    armed = 1'b1;
                    lat   = (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, 4));
                end
                if (lat == 0) begin
                    mem_ready = 1'b1;
                    armed     = 1'b0;
                    mem_rdata = sram[mem_addr];
                    if (mem_we) sram[mem_addr] = mem_wdata;
                end else begin
                    lat--;
                end
            end else begin
                armed = 1'b0;
            end
        end
    end

    // Monitor: every new data-bus drive and every new memory request is
    // matched against the next expected entry.
    logic       doe_prev = 1'b0, mv_prev = 1'b0;
    logic [7:0] exp_b;
    req_t       exp_r;
    always @(negedge wb_clk_i) begin
        if (rst_n) begin
            if (d_oe && !doe_prev) begin
                if (rd_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_d_oe actual d_out=%0h required no drive", d_out);
                end else begin
                    exp_b = rd_q.pop_front();
                    check("read_data", {24'h0, d_out}, {24'h0, exp_b});
                end
            end
            if (mem_valid && !mv_prev) begin
                if (req_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_mem_req actual addr=%0h we=%0b required none", mem_addr, mem_we);
                end else begin
                    exp_r = req_q.pop_front();
                    check("mem_addr", {18'h0, mem_addr}, {18'h0, exp_r.addr});
                    check("mem_we", {31'h0, mem_we}, {31'h0, exp_r.we});
                    if (exp_r.we) check("mem_wdata", {24'h0, mem_wdata}, {24'h0, exp_r.wdata});
                end
            end
        end
        doe_prev = d_oe;
        mv_prev  = mem_valid;
    end

    task automatic bus_idle();
        a = 16'h0000; d_in = 8'h00;
        m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1;
    endtask

    task automatic bus_cycle(input int kind, input logic [15:0] addr, input logic [7:0] data,
                             output int wlow);
        int n;
        @(posedge wb_clk_i);
        #2;
        a = addr;
        d_in = data;
        case (kind)
            K_MRD:   begin mreq_n = 1'b0; rd_n = 1'b0; end
            K_MWR:   begin mreq_n = 1'b0; wr_n = 1'b0; end
            K_IORD:  begin iorq_n = 1'b0; rd_n = 1'b0; end
            K_IOWR:  begin iorq_n = 1'b0; wr_n = 1'b0; end
            K_INTA:  begin m1_n = 1'b0; iorq_n = 1'b0; end
            default: begin mreq_n = 1'b0; rfsh_n = 1'b0; end
        endcase
        wlow = 0;
        n = 0;
        do begin
            @(negedge wb_clk_i);
            n++;
            if (wait_n === 1'b0) wlow++;
        end while ((n < 3 || wait_n === 1'b0) && n < 400);
        if (n >= 400) begin
            checks++;
            failures++;
            $display("FAIL wait_release actual wait_n=%b required 1 within 400 cycles", wait_n);
        end
        @(posedge wb_clk_i);
        #2;
        bus_idle();
        repeat (3) @(posedge wb_clk_i);
    endtask

    function automatic logic [7:0] exp_reg(input logic [7:0] off);
        case (off)
            8'd0:    return m_vector;
            8'd1:    return {m_buserr, 5'b0, m_pend, m_ie};
            default: return m_scratch;
        endcase
    endfunction

    task automatic op_mem_read(input logic [15:0] addr, input bit expect_timeout, output int wlow);
        req_t r;
        if (addr[15:14] == 2'b00) begin
            r.addr = addr[13:0]; r.we = 1'b0; r.wdata = 8'h00;
            req_q.push_back(r);
            rd_q.push_back(expect_timeout ? 8'hFF : ref_mem[addr[13:0]]);
            if (expect_timeout) m_buserr = 1'b1;
        end
        bus_cycle(K_MRD, addr, 8'h00, wlow);
    endtask

    task automatic op_mem_write(input logic [15:0] addr, input logic [7:0] data);
        req_t r;
        int   wl;
        if (addr[15:14] == 2'b00) begin
            r.addr = addr[13:0]; r.we = 1'b1; r.wdata = data;
            req_q.push_back(r);
            ref_mem[addr[13:0]] = data;
        end
        bus_cycle(K_MWR, addr, data, wl);
    endtask

    task automatic op_io_read(input logic [15:0] addr);
        logic [7:0] off;
        int         wl;
        off = addr[7:0] - IOB;
        if (off < 8'd3) rd_q.push_back(exp_reg(off));
        bus_cycle(K_IORD, addr, 8'h00, wl);
    endtask

    task automatic op_io_write(input logic [15:0] addr, input logic [7:0] data);
        logic [7:0] off;
        int         wl;
        off = addr[7:0] - IOB;
        if (off == 8'd0) m_vector = data;
        if (off == 8'd2) m_scratch = data;
        if (off == 8'd1) begin
            m_ie = data[0];
            if (data[1]) m_pend = 1'b0;
            if (data[7]) m_buserr = 1'b0;
        end
        bus_cycle(K_IOWR, addr, data, wl);
    endtask

    task automatic op_inta();
        int wl;
        rd_q.push_back(m_vector);
        bus_cycle(K_INTA, 16'h00FF, 8'h00, wl);
        m_pend = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wl;
        int n;
        for (int i = 0; i < 16384; i++) begin
            sram[i]    = 8'($urandom);
            ref_mem[i] = sram[i];
        end
        sram[14'h0123]    = 8'h5A;
        ref_mem[14'h0123] = 8'h5A;

        #12;
        check("rst_d_out", {24'h0, d_out}, 32'h0);
        check("rst_d_oe", {31'h0, d_oe}, 32'h0);
        check("rst_wait_n", {31'h0, wait_n}, 32'h1);
        check("rst_int_n", {31'h0, int_n}, 32'h1);
        check("rst_mem_valid", {31'h0, mem_valid}, 32'h0);
        check("rst_mem_we", {31'h0, mem_we}, 32'h0);
        check("rst_bus_err", {31'h0, bus_err}, 32'h0);
        @(negedge wb_clk_i);
        rst_n = 1'b1;
        repeat (2) @(posedge wb_clk_i);

        op_io_read(16'h0010);
        op_io_read(16'h0012);

        fix_lat = 3;
        op_mem_read(16'h0123, 1'b0, wl);
        checks++;
        if (wl < 3 || wl > 6) begin
            failures++;
            $display("FAIL wait_stretch actual=%0d required 3..6 cycles", wl);
        end
        fix_lat = -1;

        op_mem_write(16'h0200, 8'hC3);
        check("sram_0200", {24'h0, sram[14'h0200]}, 32'hC3);

        op_io_write(16'h0010, 8'h40);
        op_io_write(16'hAB11, 8'h01);
        @(posedge wb_clk_i);
        #2;
        irq_i = 1'b1;
        m_pend = 1'b1;
        n = 0;
        do begin @(negedge wb_clk_i); n++; end while (int_n !== 1'b0 && n < 10);
        check("int_n_assert", {31'h0, int_n}, 32'h0);
        op_io_read(16'h0011);
        op_inta();
        repeat (2) @(negedge wb_clk_i);
        check("int_n_after_inta", {31'h0, int_n}, 32'h1);
        irq_i = 1'b0;
        op_io_read(16'h0011);

        op_io_write(16'h0011, 8'h00);
        @(posedge wb_clk_i);
        #2;
        irq_i = 1'b1;
        m_pend = 1'b1;
        repeat (6) @(negedge wb_clk_i);
        check("int_n_masked", {31'h0, int_n}, 32'h1);
        irq_i = 1'b0;
        op_io_read(16'h0011);
        op_io_write(16'h0011, 8'h02);
        op_io_read(16'h0011);

        op_mem_read(16'h8000, 1'b0, wl);
        check("oow_no_wait", wl, 0);
        bus_cycle(K_RFSH, 16'h0123, 8'h00, wl);
        check("rfsh_no_wait", wl, 0);
        op_io_read(16'h0013);
        op_mem_write(16'hC000, 8'h77);

        for (int i = 0; i < 60; i++) begin
            logic [15:0] ad;
            logic [7:0]  dt;
            ad = 16'($urandom);
            dt = 8'($urandom);
            case ($urandom_range(0, 7))
                0, 1: op_mem_read({2'b00, ad[13:0]}, 1'b0, wl);
                2, 3: op_mem_write({2'b00, ad[13:0]}, dt);
                4:    op_io_read({ad[15:8], IOB + 8'($urandom_range(0, 4))});
                5:    op_io_write({ad[15:8], IOB + 8'($urandom_range(0, 4))}, dt);
                6:    bus_cycle(K_RFSH, ad, 8'h00, wl);
                default: op_mem_read({2'(1 + $urandom_range(0, 2)), ad[13:0]}, 1'b0, wl);
            endcase
        end
        check("int_n_model", {31'h0, int_n}, {31'h0, ~(m_pend & m_ie)});

        op_io_write(16'h0011, 8'h00);
        stall = 1'b1;
        op_mem_read(16'h0300, 1'b1, wl);
        stall = 1'b0;
        check("timeout_wait_cycles", wl, 255);
        check("bus_err_set", {31'h0, bus_err}, 32'h1);
        op_io_read(16'h0011);
        op_io_write(16'h0011, 8'h80);
        check("bus_err_clear", {31'h0, bus_err}, 32'h0);
        op_io_read(16'h0011);

        begin
            req_t r;
            r.addr = 14'h0040; r.we = 1'b0; r.wdata = 8'h00;
            req_q.push_back(r);
        end
        stall = 1'b1;
        @(posedge wb_clk_i);
        #2;
        a = 16'h0040; mreq_n = 1'b0; rd_n = 1'b0;
        n = 0;
        do begin @(negedge wb_clk_i); n++; end while (wait_n !== 1'b0 && n < 10);
        check("mid_mrd_wait_low", {31'h0, wait_n}, 32'h0);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_wait_n", {31'h0, wait_n}, 32'h1);
        check("abort_d_oe", {31'h0, d_oe}, 32'h0);
        check("abort_mem_valid", {31'h0, mem_valid}, 32'h0);
        bus_idle();
        stall = 1'b0;
        repeat (3) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        rst_n = 1'b1;
        m_vector = 8'hFF; m_scratch = 8'h00; m_ie = 1'b0; m_pend = 1'b0; m_buserr = 1'b0;
        repeat (2) @(posedge wb_clk_i);
        op_io_read(16'h0010);
        op_io_read(16'h0012);
        op_mem_read(16'h0123, 1'b0, wl);

        repeat (4) @(negedge wb_clk_i);
        check("rd_queue_empty", rd_q.size(), 0);
        check("req_queue_empty", req_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
